// File: rtl/aud_pkg.sv
// ----------------------------------------------------------------------------
// aud_pkg
// Shared definitions for the sound-effect scheduler: sample-tick divider,
// sample width and the scheduler FSM state encoding.
// ----------------------------------------------------------------------------
package aud_pkg;

    // 18.432 MHz / 48 kHz
    localparam int TICK_DIV = 384;
    localparam int SMP_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH     = 2'd1,
        ST_WAIT_TICK = 2'd2
    } aud_state_e;

endpackage

// File: rtl/aud_prio_enc.sv
// ----------------------------------------------------------------------------
// aud_prio_enc
// Lowest-index-first priority encoder.
// Ports:
//   req    in   N       request vector, bit 0 has the highest priority
//   valid  out  1       at least one request bit is set
//   index  out  IDX_W   index of the lowest set bit (0 when none is set)
// ----------------------------------------------------------------------------
module aud_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    assign valid = |req;

    // Scan from the top down so the lowest set index is the last one to win.
    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            index = req[i] ? IDX_W'(i) : index;
        end
    end

endmodule

// File: rtl/aud_sfx_scheduler.sv
// ----------------------------------------------------------------------------
// aud_sfx_scheduler
// Arbitrates NUM_SFX sound-effect triggers onto one mono sample stream,
// fetching sample words from a shared SRAM port (req/ack) and presenting one
// 16-bit sample per 48 kHz tick to the DAC shifter.
// Ports:
//   iCLK_18_4    in   1               system audio clock
//   iRST_N       in   1               asynchronous active-low reset
//   iTRIG        in   NUM_SFX         one-cycle trigger per effect
//   iSFX_BASE    in   NUM_SFX*ADDR_W  packed start word address per effect
//   iSFX_LEN     in   NUM_SFX*LEN_W   packed sample count per effect (0 = off)
//   oMEM_REQ     out  1               SRAM read request
//   oMEM_ADDR    out  ADDR_W          SRAM word address (0 while no request)
//   iMEM_ACK     in   1               one-cycle acknowledge, data valid with it
//   iMEM_DATA    in   16              sample word
//   oSAMPLE      out  16              current sample, held between ticks
//   oSAMPLE_VLD  out  1               pulse when oSAMPLE updates
//   oBUSY        out  1               an effect is playing
//   oACTIVE_ID   out  ID_W            playing effect index, 0 when idle
//   oUNDERRUN    out  1               pulse when a tick found no fetched sample
// ----------------------------------------------------------------------------
module aud_sfx_scheduler
    import aud_pkg::*;
#(
    parameter int NUM_SFX  = 4,
    parameter int ADDR_W   = 18,
    parameter int LEN_W    = 16,
    parameter int TICK_DIV_P = TICK_DIV,
    localparam int ID_W    = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1
) (
    input  logic                      iCLK_18_4,
    input  logic                      iRST_N,
    input  logic [NUM_SFX-1:0]        iTRIG,
    input  logic [NUM_SFX*ADDR_W-1:0] iSFX_BASE,
    input  logic [NUM_SFX*LEN_W-1:0]  iSFX_LEN,
    output logic                      oMEM_REQ,
    output logic [ADDR_W-1:0]         oMEM_ADDR,
    input  logic                      iMEM_ACK,
    input  logic [SMP_W-1:0]          iMEM_DATA,
    output logic [SMP_W-1:0]          oSAMPLE,
    output logic                      oSAMPLE_VLD,
    output logic                      oBUSY,
    output logic [ID_W-1:0]           oACTIVE_ID,
    output logic                      oUNDERRUN
);

    localparam int CNT_W = (TICK_DIV_P > 1) ? $clog2(TICK_DIV_P) : 1;

    logic [CNT_W-1:0]   cnt_r;
    logic [NUM_SFX-1:0] pend_r;
    aud_state_e         state_r;
    logic [ID_W-1:0]    id_r;
    logic [LEN_W-1:0]   ptr_r;
    logic [SMP_W-1:0]   buf_r;
    logic [SMP_W-1:0]   sample_r;
    logic               vld_r;
    logic               undr_r;

    logic               tick_s;
    logic [NUM_SFX-1:0] len_nz_s;
    logic [NUM_SFX-1:0] set_s;
    logic [NUM_SFX-1:0] clr_s;
    logic               win_vld_s;
    logic [ID_W-1:0]    win_id_s;
    logic [LEN_W-1:0]   len_cur_s;
    logic [ADDR_W-1:0]  base_cur_s;
    logic               pend_cur_s;
    logic [LEN_W-1:0]   ptr_inc_s;
    logic [LEN_W-1:0]   cur_ptr_s;
    logic               decide_s;
    logic               done_s;
    logic               preempt_s;
    logic               grant_s;
    logic [ADDR_W-1:0]  addr_s;

    assign tick_s = (cnt_r == CNT_W'(TICK_DIV_P - 1));

    aud_prio_enc #(
        .N     (NUM_SFX),
        .IDX_W (ID_W)
    ) u_prio (
        .req   (pend_r),
        .valid (win_vld_s),
        .index (win_id_s)
    );

    // Per-effect decode: enabled lengths, and the active effect's LEN/BASE/pend bit.
    always_comb begin
        len_nz_s   = '0;
        len_cur_s  = '0;
        base_cur_s = '0;
        pend_cur_s = 1'b0;
        for (int i = 0; i < NUM_SFX; i++) begin
            len_nz_s[i] = |iSFX_LEN[i*LEN_W +: LEN_W];
            len_cur_s   = (id_r == ID_W'(i)) ? iSFX_LEN[i*LEN_W +: LEN_W]    : len_cur_s;
            base_cur_s  = (id_r == ID_W'(i)) ? iSFX_BASE[i*ADDR_W +: ADDR_W] : base_cur_s;
            pend_cur_s  = (id_r == ID_W'(i)) ? pend_r[i]                     : pend_cur_s;
        end
    end

    // Tick-time play decision. An ACK landing on the tick counts as already
    // fetched, so the pointer used for the end-of-effect test is ptr+1.
    always_comb begin
        ptr_inc_s = ptr_r + LEN_W'(1);
        cur_ptr_s = (state_r == ST_FETCH) ? ptr_inc_s : ptr_r;
        done_s    = (cur_ptr_s == len_cur_s);
        preempt_s = win_vld_s && ((win_id_s < id_r) || pend_cur_s);
        decide_s  = tick_s && ((state_r == ST_WAIT_TICK) ||
                               ((state_r == ST_FETCH) && iMEM_ACK));
        grant_s   = (tick_s && (state_r == ST_IDLE) && win_vld_s) ||
                    (decide_s && (done_s ? win_vld_s : preempt_s));
        set_s     = iTRIG & len_nz_s;
        for (int i = 0; i < NUM_SFX; i++) begin
            clr_s[i] = grant_s && (win_id_s == ID_W'(i));
        end
    end

    assign addr_s      = base_cur_s + ADDR_W'(ptr_r);
    assign oMEM_REQ    = (state_r == ST_FETCH);
    assign oMEM_ADDR   = oMEM_REQ ? addr_s : '0;
    assign oBUSY       = (state_r != ST_IDLE);
    assign oACTIVE_ID  = id_r;
    assign oSAMPLE     = sample_r;
    assign oSAMPLE_VLD = vld_r;
    assign oUNDERRUN   = undr_r;

    // Tick counter, pending triggers, scheduler FSM and output sample register.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_r    <= '0;
            pend_r   <= '0;
            state_r  <= ST_IDLE;
            id_r     <= '0;
            ptr_r    <= '0;
            buf_r    <= '0;
            sample_r <= '0;
            vld_r    <= 1'b0;
            undr_r   <= 1'b0;
        end else begin
            cnt_r  <= tick_s ? '0 : cnt_r + CNT_W'(1);
            // A new trigger overrides a grant-clear of the same bit.
            pend_r <= (pend_r & ~clr_s) | set_s;
            vld_r  <= 1'b0;
            undr_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (tick_s) begin
                        sample_r <= '0;
                        vld_r    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (iMEM_ACK) begin
                        buf_r <= iMEM_DATA;
                        if (tick_s) begin
                            sample_r <= iMEM_DATA;
                            vld_r    <= 1'b1;
                        end
                    end else if (tick_s) begin
                        sample_r <= '0;
                        vld_r    <= 1'b1;
                        undr_r   <= 1'b1;
                    end
                end
                ST_WAIT_TICK: begin
                    if (tick_s) begin
                        sample_r <= buf_r;
                        vld_r    <= 1'b1;
                    end
                end
                default: begin
                    sample_r <= '0;
                end
            endcase

            if (grant_s) begin
                id_r    <= win_id_s;
                ptr_r   <= '0;
                state_r <= ST_FETCH;
            end else if (decide_s && done_s) begin
                id_r    <= '0;
                ptr_r   <= '0;
                state_r <= ST_IDLE;
            end else if (decide_s) begin
                ptr_r   <= cur_ptr_s;
                state_r <= ST_FETCH;
            end else if ((state_r == ST_FETCH) && iMEM_ACK) begin
                ptr_r   <= ptr_inc_s;
                state_r <= ST_WAIT_TICK;
            end else if ((state_r != ST_IDLE) && (state_r != ST_FETCH) &&
                         (state_r != ST_WAIT_TICK)) begin
                state_r <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_aud_sfx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_aud_sfx_scheduler
// Directed bench for aud_sfx_scheduler with an SRAM responder model and a
// scoreboard of expected samples (and fetch addresses).
// ----------------------------------------------------------------------------
module tb_aud_sfx_scheduler;

    localparam int NUM_SFX = 4;
    localparam int ADDR_W  = 18;
    localparam int LEN_W   = 16;

    logic                      iCLK_18_4 = 1'b0;
    logic                      iRST_N;
    logic [NUM_SFX-1:0]        iTRIG;
    logic [NUM_SFX*ADDR_W-1:0] iSFX_BASE;
    logic [NUM_SFX*LEN_W-1:0]  iSFX_LEN;
    logic                      oMEM_REQ;
    logic [ADDR_W-1:0]         oMEM_ADDR;
    logic                      iMEM_ACK;
    logic [15:0]               iMEM_DATA;
    logic [15:0]               oSAMPLE;
    logic                      oSAMPLE_VLD;
    logic                      oBUSY;
    logic [1:0]                oACTIVE_ID;
    logic                      oUNDERRUN;

    typedef struct packed {
        logic [15:0] smp;
        logic        und;
    } exp_t;

    exp_t              exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    int                n_cmp = 0;
    int                n_err = 0;
    bit                auto_mode = 1'b0;
    bit                man_ack = 1'b0;
    logic [15:0]       man_data = 16'h0000;

    aud_sfx_scheduler dut (
        .iCLK_18_4   (iCLK_18_4),
        .iRST_N      (iRST_N),
        .iTRIG       (iTRIG),
        .iSFX_BASE   (iSFX_BASE),
        .iSFX_LEN    (iSFX_LEN),
        .oMEM_REQ    (oMEM_REQ),
        .oMEM_ADDR   (oMEM_ADDR),
        .iMEM_ACK    (iMEM_ACK),
        .iMEM_DATA   (iMEM_DATA),
        .oSAMPLE     (oSAMPLE),
        .oSAMPLE_VLD (oSAMPLE_VLD),
        .oBUSY       (oBUSY),
        .oACTIVE_ID  (oACTIVE_ID),
        .oUNDERRUN   (oUNDERRUN)
    );

    initial forever #27 iCLK_18_4 = ~iCLK_18_4;

    function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
        case (a)
            18'h00100: return 16'h1111;
            18'h00101: return 16'h2222;
            18'h00102: return 16'h3333;
            default:   return a[15:0] ^ 16'hA5A5;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] s, input logic u);
        exp_t e;
        e.smp = s;
        e.und = u;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for the next sample pulse and compare it with the scoreboard head.
    task automatic expect_tick(input string tag, output int cyc);
        exp_t e;
        cyc = 0;
        do begin
            @(negedge iCLK_18_4);
            cyc++;
        end while (oSAMPLE_VLD !== 1'b1 && cyc < 600);
        n_cmp++;
        assert (oSAMPLE_VLD === 1'b1) else begin
            n_err++;
            $error("FAIL %s_timeout: observed no VLD expected VLD within 600 cycles", tag);
        end
        if (oSAMPLE_VLD === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL %s_sb: observed extra sample %0h expected none", tag, oSAMPLE);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, "_sample"}, 32'(oSAMPLE), 32'(e.smp));
                chk({tag, "_underrun"}, 32'(oUNDERRUN), 32'(e.und));
            end
        end
    endtask

    task automatic tk(input string tag);
        int c;
        expect_tick(tag, c);
    endtask

    task automatic pulse_trig(input int idx);
        iTRIG      = '0;
        iTRIG[idx] = 1'b1;
        @(negedge iCLK_18_4);
        iTRIG      = '0;
    endtask

    task automatic set_sfx(input int idx, input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
        iSFX_BASE[idx*ADDR_W +: ADDR_W] = b;
        iSFX_LEN[idx*LEN_W +: LEN_W]    = l;
    endtask

    // SRAM responder: manual mode mirrors man_ack/man_data, auto mode acks 2+ cycles after REQ.
    initial begin
        int age;
        age       = 0;
        iMEM_ACK  = 1'b0;
        iMEM_DATA = 16'h0000;
        forever begin
            @(negedge iCLK_18_4);
            if (!auto_mode) begin
                iMEM_ACK  = man_ack;
                iMEM_DATA = man_data;
                age       = 0;
            end else if (oMEM_REQ === 1'b1 && iMEM_ACK === 1'b0 && age >= 2) begin
                iMEM_ACK  = 1'b1;
                iMEM_DATA = mem_word(oMEM_ADDR);
                if (exp_addr_q.size() > 0) begin
                    chk("mem_addr", 32'(oMEM_ADDR), 32'(exp_addr_q.pop_front()));
                end
                age = 0;
            end else begin
                iMEM_ACK = 1'b0;
                age      = (oMEM_REQ === 1'b1) ? age + 1 : 0;
            end
        end
    end

    initial begin
        int c;
        iRST_N    = 1'b0;
        iTRIG     = '0;
        iSFX_BASE = '0;
        iSFX_LEN  = '0;
        repeat (3) @(negedge iCLK_18_4);
        iRST_N = 1'b1;

        // 1. reset state and free-running tick
        chk("rst_sample", 32'(oSAMPLE), 32'h0);
        chk("rst_vld", 32'(oSAMPLE_VLD), 32'h0);
        chk("rst_req", 32'(oMEM_REQ), 32'h0);
        chk("rst_addr", 32'(oMEM_ADDR), 32'h0);
        chk("rst_busy", 32'(oBUSY), 32'h0);
        chk("rst_id", 32'(oACTIVE_ID), 32'h0);
        chk("rst_underrun", 32'(oUNDERRUN), 32'h0);
        push_exp(16'h0000, 1'b0);
        push_exp(16'h0000, 1'b0);
        expect_tick("t1_tick0", c);
        chk("t1_first_spacing", 32'(c), 32'd384);
        expect_tick("t1_tick1", c);
        chk("t1_spacing", 32'(c), 32'd384);
        chk("t1_req", 32'(oMEM_REQ), 32'h0);
        chk("t1_busy", 32'(oBUSY), 32'h0);

        // 2. basic three-sample effect on slot 2
        auto_mode = 1'b1;
        set_sfx(2, 18'h00100, 16'd3);
        exp_addr_q.push_back(18'h00100);
        exp_addr_q.push_back(18'h00101);
        exp_addr_q.push_back(18'h00102);
        push_exp(16'h0000, 1'b0);
        push_exp(16'h1111, 1'b0);
        push_exp(16'h2222, 1'b0);
        push_exp(16'h3333, 1'b0);
        push_exp(16'h0000, 1'b0);
        pulse_trig(2);
        tk("t2_grant");
        chk("t2_busy", 32'(oBUSY), 32'h1);
        chk("t2_id", 32'(oACTIVE_ID), 32'h2);
        tk("t2_s0");
        tk("t2_s1");
        tk("t2_s2");
        chk("t2_busy_end", 32'(oBUSY), 32'h0);
        tk("t2_idle");
        chk("t2_req_end", 32'(oMEM_REQ), 32'h0);
        chk("t2_addrs_done", 32'(exp_addr_q.size()), 32'h0);

        // 3. slot 3 preempted by slot 0 after five samples, never resumed
        set_sfx(3, 18'h00200, 16'd100);
        set_sfx(0, 18'h00300, 16'd2);
        for (int k = 0; k < 6; k++) exp_addr_q.push_back(18'h00200 + 18'(k));
        exp_addr_q.push_back(18'h00300);
        exp_addr_q.push_back(18'h00301);
        push_exp(16'h0000, 1'b0);
        for (int k = 0; k < 6; k++) push_exp(mem_word(18'h00200 + 18'(k)), 1'b0);
        push_exp(mem_word(18'h00300), 1'b0);
        push_exp(mem_word(18'h00301), 1'b0);
        push_exp(16'h0000, 1'b0);
        push_exp(16'h0000, 1'b0);
        pulse_trig(3);
        tk("t3_grant");
        chk("t3_id3", 32'(oACTIVE_ID), 32'h3);
        for (int k = 0; k < 5; k++) tk("t3_s3");
        pulse_trig(0);
        tk("t3_preempt");
        chk("t3_id0", 32'(oACTIVE_ID), 32'h0);
        chk("t3_busy", 32'(oBUSY), 32'h1);
        tk("t3_s0a");
        tk("t3_s0b");
        chk("t3_busy_end", 32'(oBUSY), 32'h0);
        tk("t3_idle0");
        tk("t3_idle1");
        chk("t3_no_resume", 32'(oBUSY), 32'h0);
        chk("t3_addrs_done", 32'(exp_addr_q.size()), 32'h0);

        // 4. underrun, then ACK landing exactly on the tick
        auto_mode = 1'b0;
        man_ack   = 1'b0;
        set_sfx(1, 18'h00400, 16'd2);
        exp_addr_q.push_back(18'h00401);
        push_exp(16'h0000, 1'b0);
        push_exp(16'h0000, 1'b1);
        push_exp(16'hBEEF, 1'b0);
        push_exp(mem_word(18'h00401), 1'b0);
        push_exp(16'h0000, 1'b0);
        pulse_trig(1);
        tk("t4_grant");
        chk("t4_id", 32'(oACTIVE_ID), 32'h1);
        tk("t4_underrun");
        chk("t4_addr_kept", 32'(oMEM_ADDR), 32'h00400);
        chk("t4_req_kept", 32'(oMEM_REQ), 32'h1);
        repeat (382) @(negedge iCLK_18_4);
        #1;
        man_data = 16'hBEEF;
        man_ack  = 1'b1;
        @(negedge iCLK_18_4);
        #1;
        man_ack   = 1'b0;
        auto_mode = 1'b1;
        tk("t4_ack_on_tick");
        chk("t4_next_addr", 32'(oMEM_ADDR), 32'h00401);
        tk("t4_last");
        tk("t4_idle");
        chk("t4_busy_end", 32'(oBUSY), 32'h0);
        chk("t4_addrs_done", 32'(exp_addr_q.size()), 32'h0);

        // 5. zero-length trigger ignored; address wrap at the top of SRAM
        set_sfx(1, 18'h3FFFF, 16'd0);
        push_exp(16'h0000, 1'b0);
        pulse_trig(1);
        tk("t5_ignored");
        chk("t5_ignored_busy", 32'(oBUSY), 32'h0);
        set_sfx(1, 18'h3FFFF, 16'd2);
        exp_addr_q.push_back(18'h3FFFF);
        exp_addr_q.push_back(18'h00000);
        push_exp(16'h0000, 1'b0);
        push_exp(mem_word(18'h3FFFF), 1'b0);
        push_exp(mem_word(18'h00000), 1'b0);
        push_exp(16'h0000, 1'b0);
        pulse_trig(1);
        tk("t5_grant");
        tk("t5_s0");
        tk("t5_s1");
        tk("t5_idle");
        chk("t5_addrs_done", 32'(exp_addr_q.size()), 32'h0);

        // 6. asynchronous reset in the middle of a fetch, with another effect pending
        auto_mode = 1'b0;
        man_ack   = 1'b0;
        push_exp(16'h0000, 1'b0);
        pulse_trig(2);
        tk("t6_grant");
        pulse_trig(3);
        repeat (10) @(negedge iCLK_18_4);
        chk("t6_req_before", 32'(oMEM_REQ), 32'h1);
        #5;
        iRST_N = 1'b0;
        #1;
        chk("t6_rst_req", 32'(oMEM_REQ), 32'h0);
        chk("t6_rst_addr", 32'(oMEM_ADDR), 32'h0);
        chk("t6_rst_busy", 32'(oBUSY), 32'h0);
        chk("t6_rst_id", 32'(oACTIVE_ID), 32'h0);
        chk("t6_rst_sample", 32'(oSAMPLE), 32'h0);
        chk("t6_rst_vld", 32'(oSAMPLE_VLD), 32'h0);
        @(negedge iCLK_18_4);
        iRST_N = 1'b1;
        push_exp(16'h0000, 1'b0);
        expect_tick("t6_post", c);
        chk("t6_post_spacing", 32'(c), 32'd384);
        chk("t6_pend_clear", 32'(oBUSY), 32'h0);
        chk("t6_post_req", 32'(oMEM_REQ), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
